// File: rtl/lpf_pkg.sv
// Shared types and helpers for the time-multiplexed low-pass filter engine.
package lpf_pkg;

  localparam int LPF_FRAC    = 5;
  localparam int LPF_ALPHA_W = LPF_FRAC + 1;
  localparam int LPF_UNITY   = 1 << LPF_FRAC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WB   = 2'd2
  } lpf_state_e;

  // Wraps an index that may exceed n by less than n back into 0..n-1.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return rr_wrap(idx + 1, n);
  endfunction

endpackage

// File: rtl/lpf_mac.sv
// Registered multiply-add stage: y' = (a*x + (unity-a)*y) >>> FRAC.
module lpf_mac #(
  parameter int W    = 16,
  parameter int FRAC = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic [FRAC:0]       a,
  output logic signed [W-1:0] result,
  output logic                done
);

  localparam int PW = W + FRAC + 2;
  localparam logic [FRAC:0] UNITY = {1'b1, {FRAC{1'b0}}};

  logic signed [W-1:0]  x_q, y_q;
  logic [FRAC:0]        a_q;
  logic                 v1_q, v2_q;
  logic signed [PW-1:0] p1_q, p2_q;

  logic [FRAC:0]        b;
  logic signed [PW-1:0] a_ext, b_ext, x_ext, y_ext;
  logic signed [PW-1:0] s, sh;

  // a is clamped upstream, so unity-a never wraps.
  always_comb begin
    b     = UNITY - a_q;
    a_ext = {{(PW-FRAC-1){1'b0}}, a_q};
    b_ext = {{(PW-FRAC-1){1'b0}}, b};
    x_ext = {{(PW-W){x_q[W-1]}}, x_q};
    y_ext = {{(PW-W){y_q[W-1]}}, y_q};
    s     = p1_q + p2_q;
    sh    = s >>> FRAC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      a_q  <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      p1_q <= '0;
      p2_q <= '0;
    end else begin
      v1_q <= start;
      v2_q <= v1_q;
      if (start) begin
        x_q <= x;
        y_q <= y;
        a_q <= a;
      end
      if (v1_q) begin
        p1_q <= a_ext * x_ext;
        p2_q <= b_ext * y_ext;
      end
    end
  end

  assign result = sh[W-1:0];
  assign done   = v2_q;

endmodule

// File: rtl/lpf_scheduler.sv
// Round-robin scheduler sharing one EMA datapath across NCH sensor channels.
module lpf_scheduler
  import lpf_pkg::*;
#(
  parameter int NCH           = 6,
  parameter int W             = 16,
  parameter int FRAC          = LPF_FRAC,
  parameter int ALPHA_DEFAULT = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         sample_valid,
  input  logic [NCH*W-1:0]       sample_data,
  input  logic                   cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [FRAC:0]          cfg_alpha,
  input  logic                   ovr_clr,
  output logic                   filt_valid,
  output logic [$clog2(NCH)-1:0] filt_ch,
  output logic [W-1:0]           filt_data,
  output logic [NCH*W-1:0]       filtered,
  output logic [NCH-1:0]         overrun,
  output logic                   busy
);

  localparam int CW = $clog2(NCH);
  localparam int AW = FRAC + 1;
  localparam logic [AW-1:0] UNITY     = {1'b1, {FRAC{1'b0}}};
  localparam logic [AW-1:0] ALPHA_RST = AW'(ALPHA_DEFAULT);

  logic signed [W-1:0] sample_q [NCH];
  logic signed [W-1:0] state_q  [NCH];
  logic [AW-1:0]       alpha_q  [NCH];
  logic [NCH-1:0]      pending_q, overrun_q;
  logic [NCH-1:0]      hit, ovr_set;
  logic [CW-1:0]       rr_ptr, grant_q, grant_idx;
  logic                grant_any, grant_en, wb_fire;
  logic [AW-1:0]       alpha_w;
  lpf_state_e          st, st_nxt;

  logic signed [W-1:0] mac_result;
  logic                mac_done;

  // Arbiter: first pending channel at or after rr_ptr; lowest offset wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (pending_q[rr_wrap(int'(rr_ptr) + k, NCH)]) begin
        grant_any = 1'b1;
        grant_idx = CW'(rr_wrap(int'(rr_ptr) + k, NCH));
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  // FSM: next state
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (grant_any) st_nxt = MUL;
      MUL:     st_nxt = WB;
      WB:      st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (st != IDLE);
    grant_en = (st == IDLE) && grant_any;
    wb_fire  = (st == WB) && mac_done;
  end

  // sample_valid is a one-cycle strobe with no back-pressure: a capture is
  // always accepted, and an unserviced older sample is overwritten (overrun).
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      hit[c]     = grant_en && (grant_idx == CW'(c));
      ovr_set[c] = sample_valid[c] && pending_q[c] && !hit[c];
    end
  end

  always_comb begin
    alpha_w = (cfg_alpha > UNITY) ? UNITY : cfg_alpha;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      overrun_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        sample_q[c] <= '0;
        alpha_q[c]  <= ALPHA_RST;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (sample_valid[c]) sample_q[c] <= sample_data[c*W +: W];
        if (cfg_we && (cfg_ch == CW'(c))) alpha_q[c] <= alpha_w;
      end
      // A capture in the grant cycle re-queues the channel with the new sample.
      pending_q <= sample_valid | (pending_q & ~hit);
      overrun_q <= ovr_set | (overrun_q & {NCH{~ovr_clr}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q    <= '0;
      rr_ptr     <= '0;
      filt_valid <= 1'b0;
      filt_ch    <= '0;
      filt_data  <= '0;
      for (int c = 0; c < NCH; c++) state_q[c] <= '0;
    end else begin
      filt_valid <= wb_fire;
      if (grant_en) grant_q <= grant_idx;
      if (wb_fire) begin
        filt_ch   <= grant_q;
        filt_data <= mac_result;
        rr_ptr    <= CW'(rr_next(int'(grant_q), NCH));
        for (int c = 0; c < NCH; c++) begin
          if (grant_q == CW'(c)) state_q[c] <= mac_result;
        end
      end
    end
  end

  lpf_mac #(
    .W    (W),
    .FRAC (FRAC)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (grant_en),
    .x      (sample_q[grant_idx]),
    .y      (state_q[grant_idx]),
    .a      (alpha_q[grant_idx]),
    .result (mac_result),
    .done   (mac_done)
  );

  for (genvar c = 0; c < NCH; c++) begin : g_flat
    assign filtered[c*W +: W] = state_q[c];
  end

  assign overrun = overrun_q;

endmodule

// File: doc/lpf_scheduler.md
# lpf_scheduler

Time-multiplexed low-pass filter engine for the IMU front end. It accepts raw 16-bit samples from up to NCH sensor channels (gyro/accel axes) and arbitrates them round-robin onto one shared registered multiply-add datapath. That datapath computes a per-channel exponential moving average. The block sits between the sensor readout and the attitude estimator, replacing one filter instance per axis. Per-channel alpha is runtime-configurable.

## Interface
- NCH, 6, number of channels (2..16)
- W, 16, sample/state width (signed)
- FRAC, 5, alpha fractional bits; alpha unity = 2^FRAC
- ALPHA_DEFAULT, 14, reset alpha for every channel
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- sample_valid  in  NCH  one-cycle strobe per channel
- sample_data  in  NCH*W  channel c at [c*W +: W], signed
- cfg_we  in  1  alpha write strobe
- cfg_ch  in  $clog2(NCH)  target channel of write
- cfg_alpha  in  FRAC+1  unsigned alpha; values > 2^FRAC clamp to 2^FRAC
- ovr_clr  in  1  clears all overrun flags
- filt_valid  out  1  one-cycle pulse per completed update
- filt_ch  out  $clog2(NCH)  channel of current filt_valid
- filt_data  out  W  new filtered value for filt_ch
- filtered  out  NCH*W  per-channel filter state, flat bus
- overrun  out  NCH  sticky: sample overwritten before service
- busy  out  1  FSM not in IDLE

## Operation
- Per channel: sample register, pending bit, alpha register, state register y.
- Capture: sample_valid[c] loads the sample register and sets pending[c]. If pending[c] is already set and not being granted this cycle, set overrun[c]; the newest sample wins.
- FSM states are IDLE, MUL and WB.
  - IDLE: if any pending bit is set, grant the first pending channel at or after rr_ptr, cyclically. Latch x = sample, y = state and a = alpha into operand registers, clear pending[g] and go to MUL.
  - MUL: register p1 = a*x and p2 = (2^FRAC - a)*y, signed, W+FRAC+2 bits. Go to WB.
  - WB: compute s = p1 + p2 and result = s >>> FRAC (arithmetic shift, floor). Truncate to W bits; the convex combination guarantees no overflow. Write state[g], drive filt_* and set rr_ptr = g+1 mod NCH. Go to IDLE.
- Grant and capture of the same channel in the same cycle: the operands take the old sample, pending stays set and the new sample is queued. overrun is not set.
- ovr_clr and a capture-overrun in the same cycle: set wins.
- Config write: applies to any operation granted after the write edge. An operation already latched is unaffected.
- filtered[c] reflects state[c] directly.

## Timing
- Reset (async assert, sync-safe deassert): all states 0, samples 0, pending 0, overrun 0, alpha = ALPHA_DEFAULT, rr_ptr 0, FSM IDLE, filt_valid 0, filt_ch 0, filt_data 0, busy 0.
- Latency from sample_valid in cycle t, block idle:
  - grant in t+1
  - MUL in t+2
  - WB in t+3
  - filt_valid, filt_data and filtered updated in t+4
- Throughput: one update per 3 cycles; back-to-back grants occur every third cycle.
- Reset asserted mid-operation: the in-flight result is discarded and nothing is written.
- filt_valid is registered and high for exactly one cycle.

## Structure
- lpf_pkg holds:
  - FSM state enum (IDLE, MUL, WB)
  - FRAC, ALPHA_W = FRAC+1 and the unity constant
  - the round-robin next-index function
- Sub-module lpf_mac holds the operand registers, the product registers and the add/shift stage. Its inputs are x, y, a and start; its outputs are result and done.
- The top level holds the capture, arbiter, FSM, register file and config.

## Test plan
- ch0, alpha 14, state 0: sample 1000 -> filt_data 437 at t+4. Second sample 1000 -> 683.
- ch1, sample -1000 from state 0 -> -438 (floor rounding).
- cfg alpha 32 on ch2, sample 12345 -> 12345. cfg alpha 40 reads as clamped 32 with the same result. cfg alpha 0 -> state unchanged.
- Samples on ch0, ch2 and ch5 in the same cycle t -> filt_valid at t+4, t+7 and t+10 with filt_ch 0, 2, 5. Then ch0 and ch1 both pending with rr_ptr=1 -> ch1 is served first.
- ch3 sampled twice before its grant -> overrun[3]=1 and the second value is used. ch3 sampled in its grant cycle -> no overrun and two updates. ovr_clr -> 0.
- rst_n low during MUL -> all outputs at reset values and no filt_valid. After release, the next sample computes from state 0.
